ro_freq_meas_ctrl: RTL and testbench
====================================

// Module: ro_freq_meas_ctrl
// PURPOSE
//  Sequences one ring-oscillator stage (e.g. 61-stage RO used for LNFB/GNFB): enables it through its start pin,
//  lets it settle, counts oscillator rising edges over a programmable window of clk cycles, then disables it.
//  Result feeds the current-source controller loop as a digital frequency code. RO runs only while measuring.
// PARAMETERS
//  CNT_W      16  width of RO edge counter and result (modulo 2^CNT_W)
//  WIN_W      12  width of window length input (clk cycles)
//  WARMUP_CYC  8  clk cycles ro_start held high before first snapshot (RO settle); must be >= 3
//  SYNC_STG    2  synchronizer flops on gray count crossing osc->clk
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      async active-low reset
//  meas_req    in   1      level; sampled in IDLE only, starts one measurement
//  meas_abort  in   1      cancel measurement in progress
//  win_cycles  in   WIN_W  window length, latched on accept
//  osc_in      in   1      RO output (osc_out of RO)
//  ro_start    out  1      RO enable (drives RO start pin)
//  busy        out  1      high from accept until done/abort
//  done        out  1      1-cycle pulse, count_out valid
//  count_out   out  CNT_W  edges counted in window; held until next done
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, ro_start=0, busy=0, done=0, count_out=0; edge counter cleared.
//  - FSM: IDLE -> WARMUP -> COUNT -> STOP -> IDLE. All outputs registered.
//  - IDLE: meas_req=1 -> latch win_cycles into win_q, go WARMUP; busy=1 and ro_start=1 from next cycle.
//  - WARMUP: hold ro_start=1 for WARMUP_CYC cycles; last cycle captures synced gray count -> base (binary).
//  - COUNT: down-counter from win_q; at zero capture synced count -> end, go STOP. Window = exactly win_q clk cycles
//    between base and end snapshots.
//  - STOP: ro_start=0; count_out <= end - base (mod 2^CNT_W); done=1 for one cycle; busy=0; back to IDLE.
//  - Latency request->done = 1 + WARMUP_CYC + win_q + 1 cycles (+ gray sync delay absorbed equally by both snapshots).
//  - win_cycles==0: COUNT skipped, count_out=0, done still pulses.
//  - meas_req while busy: ignored (not queued). meas_req held high: new measurement starts the cycle after done.
//  - meas_abort (any non-IDLE state): ro_start=0 and busy=0 next cycle, no done, count_out unchanged. Abort wins
//    over simultaneous window completion. Abort in IDLE: no effect, and suppresses a same-cycle meas_req.
//  - Edge counter: CNT_W-bit gray counter clocked by osc_in, async-cleared by rst_n; never cleared between
//    measurements (difference arithmetic handles wrap). Counter freezes when RO stopped; no glitch on resume.
//  - Wrap: result correct if true edge count < 2^CNT_W; integrator sizes CNT_W/win_cycles accordingly.
//  - Reset mid-measurement: immediate ro_start=0, all state as reset; no done.
// CONFIGURATION
//  Macro RO_FREQ_THRESH_EN:
//   defined -> extra ports thr_lo/thr_hi (in, CNT_W) and too_slow/too_fast (out, 1), registered with done:
//     too_slow = count_out < thr_lo, too_fast = count_out > thr_hi; reset 0; held until next done.
//   undefined -> ports absent, no compare logic.
// STRUCTURE
//  Shared package ro_ctrl_pkg: FSM state typedef (IDLE/WARMUP/COUNT/STOP), bin2gray/gray2bin functions,
//   default CNT_W/WIN_W constants.
//  Sub-module ro_gray_counter: osc_in-clocked gray counter + SYNC_STG synchronizer into clk, output binary.
//  Top holds FSM, window counter, snapshot/subtract, optional threshold compare.
// TESTING (bench uses behavioural RO: period set in ns, gated by ro_start)
//  - clk 10ns, osc 4ns, WARMUP_CYC=8, win=100 -> done at cycle 110 after req; count_out 250+/-1; ro_start low after.
//  - win=0 -> done 10 cycles after req, count_out=0; ro_start high only during WARMUP.
//  - Base near wrap (preload counter to 2^CNT_W-50), win=100 @4ns -> count_out 250+/-1 (wrap handled).
//  - meas_abort in COUNT cycle 40 -> ro_start=0, busy=0 next cycle, no done, count_out = previous value.
//  - meas_req held high, 3 back-to-back runs -> three done pulses spaced exactly 1+8+win+1 cycles; mid-run pulses ignored.
//  - RO_FREQ_THRESH_EN, thr_lo=240 thr_hi=260: osc 4ns -> both 0; 5ns (200) -> too_slow=1; 3ns (~333) -> too_fast=1.

Source files
------------

// File: rtl/ro_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator frequency measurement block.
`timescale 1ns/1ps
package ro_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WARMUP = 2'd1;
  localparam state_t ST_COUNT  = 2'd2;
  localparam state_t ST_STOP   = 2'd3;

  // Conversions work on up to 32 bits; callers zero-extend and truncate to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ro_gray_counter.sv
// Gray-coded edge counter clocked by the ring oscillator, synchronised into clk
// and presented as binary. Only one bit changes per edge, so a sample is never torn.
`timescale 1ns/1ps
module ro_gray_counter
  import ro_ctrl_pkg::*;
#(
  parameter int              CNT_W    = CNT_W_DEF,
  parameter int              SYNC_STG = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  output logic [CNT_W-1:0] cnt_bin
);

  localparam logic [CNT_W-1:0] RST_GRAY = CNT_W'(bin2gray(32'(RST_VAL)));

  logic [CNT_W-1:0]               gray_r;
  logic [CNT_W-1:0]               inc_bin_s;
  logic [SYNC_STG-1:0][CNT_W-1:0] sync_r;

  assign inc_bin_s = CNT_W'(gray2bin(32'(gray_r))) + CNT_W'(1);

  // Oscillator-domain counter: advances one gray step per RO rising edge
  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      gray_r <= RST_GRAY;
    end else begin
      gray_r <= CNT_W'(bin2gray(32'(inc_bin_s)));
    end
  end

  // Synchroniser chain carrying the gray value into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STG; i++) begin
        sync_r[i] <= RST_GRAY;
      end
    end else begin
      sync_r[0] <= gray_r;
      for (int i = 1; i < SYNC_STG; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign cnt_bin = CNT_W'(gray2bin(32'(sync_r[SYNC_STG-1])));

endmodule

// File: rtl/ro_freq_meas_ctrl.sv
// Ring-oscillator frequency measurement sequencer: enable RO, settle, count edges over a
// window of clk cycles, disable RO. Optional limit flags under macro RO_FREQ_THRESH_EN.
`timescale 1ns/1ps
module ro_freq_meas_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               WIN_W       = WIN_W_DEF,
  parameter int               WARMUP_CYC  = 8,
  parameter int               SYNC_STG    = 2,
  parameter logic [CNT_W-1:0] CNT_RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_req,
  input  logic             meas_abort,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic             osc_in,
`ifdef RO_FREQ_THRESH_EN
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  output logic             too_slow,
  output logic             too_fast,
`endif
  output logic             ro_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_out
);

  localparam int                WARM_W    = $clog2(WARMUP_CYC);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);

  state_t            state_r;
  logic [WIN_W-1:0]  win_q_r;
  logic [WIN_W-1:0]  win_cnt_r;
  logic [WARM_W-1:0] warm_cnt_r;
  logic [CNT_W-1:0]  base_r;
  logic [CNT_W-1:0]  end_r;
  logic [CNT_W-1:0]  count_r;
  logic              ro_start_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  cnt_bin_s;
  logic [CNT_W-1:0]  diff_s;
  logic              fin_s;

  ro_gray_counter #(
    .CNT_W   (CNT_W),
    .SYNC_STG(SYNC_STG),
    .RST_VAL (CNT_RST_VAL)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .cnt_bin(cnt_bin_s)
  );

  // Modulo subtraction absorbs counter wrap between the two snapshots
  assign diff_s = end_r - base_r;
  assign fin_s  = (state_r == ST_STOP) && !meas_abort;

  // Measurement sequencer: accept, warm-up, counting window, stop/publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      win_q_r    <= '0;
      win_cnt_r  <= '0;
      warm_cnt_r <= '0;
      base_r     <= '0;
      end_r      <= '0;
      count_r    <= '0;
      ro_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (meas_abort && (state_r != ST_IDLE)) begin
        state_r    <= ST_IDLE;
        ro_start_r <= 1'b0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // An abort in IDLE also blocks a same-cycle request
            if (meas_req && !meas_abort) begin
              win_q_r    <= win_cycles;
              warm_cnt_r <= WARM_LAST;
              ro_start_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= ST_WARMUP;
            end
          end
          ST_WARMUP: begin
            if (warm_cnt_r == '0) begin
              base_r    <= cnt_bin_s;
              win_cnt_r <= win_q_r;
              if (win_q_r == '0) begin
                end_r      <= cnt_bin_s;
                ro_start_r <= 1'b0;
                state_r    <= ST_STOP;
              end else begin
                state_r <= ST_COUNT;
              end
            end else begin
              warm_cnt_r <= warm_cnt_r - WARM_W'(1);
            end
          end
          ST_COUNT: begin
            if (win_cnt_r == WIN_W'(1)) begin
              end_r      <= cnt_bin_s;
              ro_start_r <= 1'b0;
              state_r    <= ST_STOP;
            end else begin
              win_cnt_r <= win_cnt_r - WIN_W'(1);
            end
          end
          ST_STOP: begin
            count_r <= diff_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r    <= ST_IDLE;
            ro_start_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RO_FREQ_THRESH_EN
  logic too_slow_r;
  logic too_fast_r;

  // Limit flags refresh together with count_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      too_slow_r <= 1'b0;
      too_fast_r <= 1'b0;
    end else if (fin_s) begin
      too_slow_r <= (diff_s < thr_lo);
      too_fast_r <= (diff_s > thr_hi);
    end
  end

  assign too_slow = too_slow_r;
  assign too_fast = too_fast_r;
`endif

  assign ro_start  = ro_start_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count_out = count_r;

endmodule

// File: tb/tb_ro_freq_meas_ctrl.sv
// Bench for ro_freq_meas_ctrl with a behavioural RO gated by ro_start.
// Limit-flag checks are compiled in when RO_FREQ_THRESH_EN is defined.
`timescale 1ns/1ps
module tb_ro_freq_meas_ctrl;

  localparam int               CNT_W      = 16;
  localparam int               WIN_W      = 12;
  localparam int               WARMUP_CYC = 8;
  localparam real              CLK_NS     = 10.0;
  localparam logic [CNT_W-1:0] PRELOAD    = 16'hFFCE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             meas_req = 1'b0;
  logic             meas_abort = 1'b0;
  logic [WIN_W-1:0] win_cycles = '0;
  logic             osc_in;
  logic             ro_start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count_out;
`ifdef RO_FREQ_THRESH_EN
  logic [CNT_W-1:0] thr_lo = 16'd240;
  logic [CNT_W-1:0] thr_hi = 16'd260;
  logic             too_slow;
  logic             too_fast;
`endif

  int  osc_per = 4;
  int  n_checks = 0;
  int  n_fail = 0;

  typedef struct {
    int win;
    int per;
    int exp_cnt;
  } vec_t;

  vec_t vecs [6];

  ro_freq_meas_ctrl #(
    .CNT_W      (CNT_W),
    .WIN_W      (WIN_W),
    .WARMUP_CYC (WARMUP_CYC),
    .SYNC_STG   (2),
    .CNT_RST_VAL(PRELOAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .meas_req  (meas_req),
    .meas_abort(meas_abort),
    .win_cycles(win_cycles),
    .osc_in    (osc_in),
`ifdef RO_FREQ_THRESH_EN
    .thr_lo    (thr_lo),
    .thr_hi    (thr_hi),
    .too_slow  (too_slow),
    .too_fast  (too_fast),
`endif
    .ro_start  (ro_start),
    .busy      (busy),
    .done      (done),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  // Behavioural ring oscillator: free-runs with period osc_per ns while enabled
  always begin
    osc_in = 1'b0;
    wait (ro_start === 1'b1);
    while (ro_start === 1'b1) begin
      #(osc_per / 2.0) osc_in = 1'b1;
      #(osc_per / 2.0) osc_in = 1'b0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge count over a window is floor/ceil of window/period; allow one edge of slack
  task automatic check_near(input string name, input longint act, input real exp);
    real d;
    n_checks++;
    d = real'(act) - exp;
    if (d > 1.0 || d < -1.0) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0.2f +/-1", name, act, exp);
    end
  endtask

  // One measurement; lat = negedges from request until done seen (-1 on timeout)
  task automatic run_meas(input int win, input int per, input int poke_at,
                          output int lat, output int ro_cyc);
    lat = -1;
    ro_cyc = 0;
    @(negedge clk);
    osc_per    = per;
    win_cycles = WIN_W'(win);
    meas_req   = 1'b1;
    for (int n = 1; n <= win + 60 && lat < 0; n++) begin
      @(negedge clk);
      meas_req   = (n == poke_at);
      win_cycles = (n == poke_at) ? WIN_W'(5) : WIN_W'(win);
      if (ro_start) ro_cyc++;
      if (done) lat = n;
    end
    meas_req = 1'b0;
  endtask

  task automatic full_check(input string tag, input int win, input int per, input real exp_cnt,
                            input int poke_at);
    int lat, roc;
    run_meas(win, per, poke_at, lat, roc);
    check({tag, "_latency"}, lat, WARMUP_CYC + win + 2);
    check_near({tag, "_count"}, count_out, exp_cnt);
    check({tag, "_ro_cycles"}, roc, WARMUP_CYC + win);
    check({tag, "_ro_off_at_done"}, ro_start, 0);
    check({tag, "_busy_at_done"}, busy, 0);
`ifdef RO_FREQ_THRESH_EN
    check({tag, "_too_slow"}, too_slow, (exp_cnt < 240.0) ? 1 : 0);
    check({tag, "_too_fast"}, too_fast, (exp_cnt > 260.0) ? 1 : 0);
`endif
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int w, p, k, dn;
    int dt [3];
    vecs[0] = '{win: 100, per: 4, exp_cnt: 250};
    vecs[1] = '{win: 0,   per: 4, exp_cnt: 0};
    vecs[2] = '{win: 100, per: 5, exp_cnt: 200};
    vecs[3] = '{win: 90,  per: 3, exp_cnt: 300};
    vecs[4] = '{win: 37,  per: 5, exp_cnt: 74};
    vecs[5] = '{win: 200, per: 8, exp_cnt: 250};

    repeat (3) @(negedge clk);
    check("rst_ro_start", ro_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count_out", count_out, 0);
    rst_n = 1'b1;

    // Directed table; first entry starts near counter wrap
    for (int i = 0; i < 6; i++) begin
      full_check($sformatf("vec%0d", i), vecs[i].win, vecs[i].per, real'(vecs[i].exp_cnt), 0);
    end

    // Randomised windows and periods against window*Tclk/Tosc
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, 150);
      p = $urandom_range(3, 9);
      full_check($sformatf("rnd%0d", i), w, p, real'(w) * CLK_NS / real'(p), 0);
    end

    // Request pulse mid-run with a different window must be ignored
    full_check("ignore_req", 50, 4, 125.0, 20);

    // Abort in COUNT cycle 40
    full_check("pre_abort", 100, 4, 250.0, 0);
    dn = 0;
    @(negedge clk);
    win_cycles = WIN_W'(100);
    osc_per = 5;
    meas_req = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      meas_req = 1'b0;
      if (done) dn++;
    end
    check("abort_busy_before", busy, 1);
    check("abort_ro_before", ro_start, 1);
    meas_abort = 1'b1;
    @(negedge clk);
    meas_abort = 1'b0;
    check("abort_ro_off", ro_start, 0);
    check("abort_busy_off", busy, 0);
    repeat (150) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check_near("abort_count_held", count_out, 250.0);

    // Abort in IDLE blocks a same-cycle request
    @(negedge clk);
    meas_req = 1'b1;
    meas_abort = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    meas_abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_ro", ro_start, 0);

    // Request held high: back-to-back runs spaced 1+8+win+1
    k = 0;
    dt[0] = -1; dt[1] = -1; dt[2] = -1;
    @(negedge clk);
    win_cycles = WIN_W'(20);
    osc_per = 4;
    meas_req = 1'b1;
    for (int n = 1; n <= 200 && k < 3; n++) begin
      @(negedge clk);
      if (done) begin
        dt[k] = n;
        check_near($sformatf("b2b_count%0d", k), count_out, 50.0);
        k++;
        if (k == 3) meas_req = 1'b0;
      end
    end
    meas_req = 1'b0;
    check("b2b_first", dt[0], 30);
    check("b2b_gap1", dt[1] - dt[0], 30);
    check("b2b_gap2", dt[2] - dt[1], 30);
    @(negedge clk);
    check("b2b_stopped", busy, 0);

    // Reset mid-measurement
    @(negedge clk);
    win_cycles = WIN_W'(100);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    repeat (28) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ro_off", ro_start, 0);
    check("mrst_busy", busy, 0);
    check("mrst_count", count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mrst_no_done", dn, 0);
    full_check("post_rst", 40, 4, 100.0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
